wb_stage: RTL and testbench

Writeback stage of the pipelined core, directly downstream of the memory stage. Accepts completed instructions (ALU result or raw load word) over a valid/ready handshake and buffers them in a 2-entry skid FIFO. Performs load byte/halfword extraction with sign or zero extension, and drives the register-file write port. Also exports a bypass copy of the value being written and a retired-instruction counter.

---
 rtl/wb_stage.sv | 154 +++++++++++++++
 tb/tb_wb_stage.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: 2-entry skid FIFO, load formatting, register-file write port
//
// Accepts completed instructions from the memory stage over mem_valid/mem_ready.
// Formats load data at push time and buffers it. Drains the head entry into the
// register file unless rf_stall is asserted.
//
// Optional feature: define WB_FWD_EN to drive the bypass port (fwd_*) from the
// register-file write. When WB_FWD_EN is undefined, the fwd_* outputs are tied to 0.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   mem_valid/ready     push handshake from the memory stage
//   mem_we, mem_rd      destination write enable / index
//   mem_is_load         result is taken from mem_load_data instead of mem_alu_result
//   mem_funct3          load type (LB/LH/LW/LBU/LHU)
//   mem_addr_lo         byte offset of the load address
//   mem_load_data       aligned RAM word
//   mem_alu_result      non-load result
//   rf_stall            register-file port busy, hold the head entry
//   rf_we/waddr/wdata   register-file write port
//   fwd_valid/rd/data   bypass copy of the register-file write
//   misalign_err        one-cycle pulse after a faulted load retires
//   retire_count        instructions retired since reset (wraps)

module wb_stage #(
  parameter int XLEN = 32,
  parameter int RAW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic            mem_we,
  input  logic [RAW-1:0]  mem_rd,
  input  logic            mem_is_load,
  input  logic [2:0]      mem_funct3,
  input  logic [1:0]      mem_addr_lo,
  input  logic [XLEN-1:0] mem_load_data,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic            rf_stall,
  output logic            rf_we,
  output logic [RAW-1:0]  rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            fwd_valid,
  output logic [RAW-1:0]  fwd_rd,
  output logic [XLEN-1:0] fwd_data,
  output logic            misalign_err,
  output logic [31:0]     retire_count
);

  logic [XLEN-1:0] buf_data  [2];
  logic [RAW-1:0]  buf_rd    [2];
  logic            buf_we    [2];
  logic            buf_fault [2];

  logic       wptr;
  logic       rptr;
  logic [1:0] count;

  logic push;
  logic pop;
  logic head_valid;

  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] fmt_data;
  logic            fmt_fault;

  // mem_ready depends only on the occupancy register, which keeps rf_stall
  // off the upstream ready path.
  assign mem_ready  = (count != 2'd2);
  assign push       = mem_valid && mem_ready;
  assign head_valid = (count != 2'd0);
  assign pop        = head_valid && !rf_stall;

  // Load formatting is done before the data enters the FIFO, so the drain
  // side is a plain register read.
  always_comb begin
    ld_byte   = mem_load_data[{mem_addr_lo, 3'b000} +: 8];
    ld_half   = mem_load_data[{mem_addr_lo[1], 4'b0000} +: 16];
    fmt_data  = mem_alu_result;
    fmt_fault = 1'b0;
    if (mem_is_load) begin
      case (mem_funct3)
        3'b000: fmt_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
        3'b001: begin
          fmt_data  = {{(XLEN-16){ld_half[15]}}, ld_half};
          fmt_fault = mem_addr_lo[0];
        end
        3'b010: begin
          fmt_data  = mem_load_data;
          fmt_fault = (mem_addr_lo != 2'b00);
        end
        3'b100: fmt_data = {{(XLEN-8){1'b0}}, ld_byte};
        3'b101: begin
          fmt_data  = {{(XLEN-16){1'b0}}, ld_half};
          fmt_fault = mem_addr_lo[0];
        end
        default: begin
          fmt_data  = '0;
          fmt_fault = 1'b1;
        end
      endcase
    end
  end

  // Payload storage has no reset; it is only observed when count says the slot is live.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wptr]  <= fmt_data;
      buf_rd[wptr]    <= mem_rd;
      buf_we[wptr]    <= mem_we;
      buf_fault[wptr] <= fmt_fault;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr         <= 1'b0;
      rptr         <= 1'b0;
      count        <= 2'd0;
      misalign_err <= 1'b0;
      retire_count <= 32'd0;
    end else begin
      if (push) wptr <= ~wptr;
      if (pop) begin
        rptr         <= ~rptr;
        retire_count <= retire_count + 32'd1;
      end
      misalign_err <= pop && buf_fault[rptr];
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign rf_waddr = head_valid ? buf_rd[rptr]   : '0;
  assign rf_wdata = head_valid ? buf_data[rptr] : '0;
  // x0 writes and faulted loads still retire, they just never reach the register file.
  assign rf_we    = pop && buf_we[rptr] && (buf_rd[rptr] != '0) && !buf_fault[rptr];

`ifdef WB_FWD_EN
  assign fwd_valid = rf_we;
  assign fwd_rd    = rf_waddr;
  assign fwd_data  = rf_wdata;
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd    = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage with a queue-based reference model

module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [4:0]  mem_rd;
  logic        mem_is_load;
  logic [2:0]  mem_funct3;
  logic [1:0]  mem_addr_lo;
  logic [31:0] mem_load_data;
  logic [31:0] mem_alu_result;
  logic        rf_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        misalign_err;
  logic [31:0] retire_count;

  wb_stage dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_rd(mem_rd),
    .mem_is_load(mem_is_load), .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo),
    .mem_load_data(mem_load_data), .mem_alu_result(mem_alu_result), .rf_stall(rf_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .misalign_err(misalign_err), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        fault;
  } ent_t;

  ent_t        q[$];
  logic [31:0] exp_cnt;
  logic        exp_mis;
  logic        chk_en;
  int          n_tests;
  int          n_fail;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference formatting from the load rules, using plain integer arithmetic.
  function automatic void model_fmt(input logic il, input logic [2:0] f3, input logic [1:0] lo,
                                    input logic [31:0] w, input logic [31:0] a,
                                    output logic [31:0] d, output logic flt);
    int unsigned b;
    int unsigned h;
    int unsigned off;
    off = lo;
    b = (w >> (8 * off)) % 256;
    h = (w >> (16 * (off / 2))) % 65536;
    d = a;
    flt = 1'b0;
    if (il) begin
      case (f3)
        3'd0: d = (b < 128) ? b : b + 32'hFFFF_FF00;
        3'd1: begin d = (h < 32768) ? h : h + 32'hFFFF_0000; flt = (off % 2) == 1; end
        3'd2: begin d = w; flt = (off != 0); end
        3'd4: d = b;
        3'd5: begin d = h; flt = (off % 2) == 1; end
        default: begin d = 32'd0; flt = 1'b1; end
      endcase
    end
  endfunction

  task automatic model_edge();
    int   sz;
    logic popped;
    ent_t e;
    if (rst) begin
      q.delete();
      exp_cnt = 32'd0;
      exp_mis = 1'b0;
    end else begin
      sz      = q.size();
      popped  = (sz > 0) && !rf_stall;
      exp_mis = popped ? q[0].fault : 1'b0;
      if (popped) begin
        exp_cnt = exp_cnt + 32'd1;
        void'(q.pop_front());
      end
      if (mem_valid && sz < 2) begin
        model_fmt(mem_is_load, mem_funct3, mem_addr_lo, mem_load_data, mem_alu_result, e.data, e.fault);
        e.rd = mem_rd;
        e.we = mem_we;
        q.push_back(e);
      end
    end
  endtask

  task automatic compare();
    logic hv;
    logic e_we;
    hv   = (q.size() > 0);
    e_we = hv && !rf_stall && q[0].we && (q[0].rd != 0) && !q[0].fault;
    chk("mem_ready", {31'd0, mem_ready}, {31'd0, q.size() != 2});
    chk("rf_we", {31'd0, rf_we}, {31'd0, e_we});
    if (!hv) begin
      chk("rf_waddr_empty", {27'd0, rf_waddr}, 32'd0);
      chk("rf_wdata_empty", rf_wdata, 32'd0);
    end else begin
      chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, q[0].rd});
      if (!q[0].fault) chk("rf_wdata", rf_wdata, q[0].data);
    end
    chk("misalign_err", {31'd0, misalign_err}, {31'd0, exp_mis});
    chk("retire_count", retire_count, exp_cnt);
`ifdef WB_FWD_EN
    chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, e_we});
    if (e_we) begin
      chk("fwd_rd", {27'd0, fwd_rd}, {27'd0, q[0].rd});
      chk("fwd_data", fwd_data, q[0].data);
    end
`else
    chk("fwd_valid", {31'd0, fwd_valid}, 32'd0);
    chk("fwd_rd", {27'd0, fwd_rd}, 32'd0);
    chk("fwd_data", fwd_data, 32'd0);
`endif
  endtask

  task automatic set_in(input logic v, input logic il, input logic [2:0] f3, input logic [1:0] lo,
                        input logic [31:0] w, input logic [31:0] a, input logic [4:0] rd, input logic we);
    mem_valid      = v;
    mem_is_load    = il;
    mem_funct3     = f3;
    mem_addr_lo    = lo;
    mem_load_data  = w;
    mem_alu_result = a;
    mem_rd         = rd;
    mem_we         = we;
  endtask

  // Push one instruction into an empty FIFO and return 2 time units into the cycle
  // in which it is the head entry.
  task automatic push1(input logic il, input logic [2:0] f3, input logic [1:0] lo,
                       input logic [31:0] w, input logic [31:0] a, input logic [4:0] rd, input logic we);
    @(negedge clk);
    set_in(1'b1, il, f3, lo, w, a, rd, we);
    @(negedge clk);
    mem_valid = 1'b0;
    #2;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    chk_en  = 1'b0;
    exp_cnt = 32'd0;
    exp_mis = 1'b0;
    rst     = 1'b1;
    rf_stall = 1'b0;
    set_in(1'b0, 1'b0, 3'd0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0);

    fork
      forever begin
        @(posedge clk);
        model_edge();
      end
      forever begin
        @(negedge clk);
        #1;
        if (chk_en) compare();
      end
    join_none

    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    #2;
    chk("reset_mem_ready", {31'd0, mem_ready}, 32'd1);
    chk("reset_rf_we", {31'd0, rf_we}, 32'd0);
    chk("reset_rf_wdata", rf_wdata, 32'd0);
    chk("reset_retire_count", retire_count, 32'd0);
    chk("reset_misalign", {31'd0, misalign_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ALU op to x5
    push1(1'b0, 3'd0, 2'd0, 32'd0, 32'h12, 5'd5, 1'b1);
    chk("alu_rf_we", {31'd0, rf_we}, 32'd1);
    chk("alu_rf_waddr", {27'd0, rf_waddr}, 32'd5);
    chk("alu_rf_wdata", rf_wdata, 32'h12);
    @(negedge clk);
    #2;
    chk("alu_retire_count", retire_count, 32'd1);

    // Load formatting of 0x80F07F81
    push1(1'b1, 3'b000, 2'd0, 32'h80F0_7F81, 32'd0, 5'd1, 1'b1);
    chk("lb_off0", rf_wdata, 32'hFFFF_FF81);
    push1(1'b1, 3'b100, 2'd3, 32'h80F0_7F81, 32'd0, 5'd2, 1'b1);
    chk("lbu_off3", rf_wdata, 32'h0000_0080);
    push1(1'b1, 3'b001, 2'd2, 32'h80F0_7F81, 32'd0, 5'd3, 1'b1);
    chk("lh_off2", rf_wdata, 32'hFFFF_80F0);
    push1(1'b1, 3'b101, 2'd0, 32'h80F0_7F81, 32'd0, 5'd4, 1'b1);
    chk("lhu_off0", rf_wdata, 32'h0000_7F81);

    // Misaligned LW
    push1(1'b1, 3'b010, 2'd2, 32'h80F0_7F81, 32'd0, 5'd7, 1'b1);
    chk("lw_mis_rf_we", {31'd0, rf_we}, 32'd0);
    @(negedge clk);
    #2;
    chk("lw_mis_pulse", {31'd0, misalign_err}, 32'd1);
    chk("lw_mis_retire", retire_count, 32'd6);
    @(negedge clk);
    #2;
    chk("lw_mis_pulse_end", {31'd0, misalign_err}, 32'd0);

    // Write to x0
    push1(1'b0, 3'd0, 2'd0, 32'd0, 32'hDEAD, 5'd0, 1'b1);
    chk("x0_rf_we", {31'd0, rf_we}, 32'd0);
    chk("x0_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    @(negedge clk);
    #2;
    chk("x0_retire", retire_count, 32'd7);

    // Stall with three back-to-back pushes
    @(negedge clk);
    rf_stall = 1'b1;
    set_in(1'b1, 1'b0, 3'd0, 2'd0, 32'd0, 32'hA, 5'd1, 1'b1);
    @(negedge clk);
    set_in(1'b1, 1'b0, 3'd0, 2'd0, 32'd0, 32'hB, 5'd2, 1'b1);
    @(negedge clk);
    set_in(1'b1, 1'b0, 3'd0, 2'd0, 32'd0, 32'hC, 5'd3, 1'b1);
    #2;
    chk("stall_ready_low", {31'd0, mem_ready}, 32'd0);
    chk("stall_no_we", {31'd0, rf_we}, 32'd0);
    @(negedge clk);
    rf_stall = 1'b0;
    #2;
    chk("drain_a_we", {31'd0, rf_we}, 32'd1);
    chk("drain_a_data", rf_wdata, 32'hA);
    @(negedge clk);
    #2;
    chk("drain_b_data", rf_wdata, 32'hB);
    chk("drain_b_ready", {31'd0, mem_ready}, 32'd1);
    @(negedge clk);
    mem_valid = 1'b0;
    #2;
    chk("drain_c_data", rf_wdata, 32'hC);
    chk("drain_c_we", {31'd0, rf_we}, 32'd1);
    @(negedge clk);
    #2;
    chk("drain_done_ready", {31'd0, mem_ready}, 32'd1);

    // Reset with two buffered entries
    @(negedge clk);
    rf_stall = 1'b1;
    set_in(1'b1, 1'b0, 3'd0, 2'd0, 32'd0, 32'h55, 5'd9, 1'b1);
    @(negedge clk);
    set_in(1'b1, 1'b0, 3'd0, 2'd0, 32'd0, 32'h66, 5'd10, 1'b1);
    @(negedge clk);
    mem_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rf_stall = 1'b0;
    #2;
    chk("rst_mid_retire", retire_count, 32'd0);
    chk("rst_mid_ready", {31'd0, mem_ready}, 32'd1);
    chk("rst_mid_we", {31'd0, rf_we}, 32'd0);
    repeat (3) @(negedge clk);

    // Randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 299) == 0);
      rf_stall = ($urandom_range(0, 9) < 3);
      set_in($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
             2'($urandom_range(0, 3)), $urandom, $urandom, 5'($urandom_range(0, 31)),
             $urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    rst = 1'b0;
    rf_stall = 1'b0;
    mem_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
